// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation codes, decode selectors, MDU states and funct constants
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;
  typedef enum logic [1:0] {SEL_ADD, SEL_SUB, SEL_OP, SEL_OP_IMM} alu_op_sel_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_e;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;
  function automatic alu_op_e f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: shared radix-2 shift-add multiply / restoring divide datapath with sign fix-up and step counter
module mdu_iter import alu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            fast_o,
  output logic            last_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN);
  logic a_neg, b_neg, is_div, an_q, an_d, bn_q, bn_d;
  logic [2:0] f3_q, f3_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] mag_a, mag_b, m_q, m_d, lo_q, lo_d, lo_step, res_q, res_d, fin, fast_res;
  logic [XLEN:0] hi_q, hi_d, hi_step, sum;
  logic [2*XLEN-1:0] prod, prod_s;
  always_comb begin
    a_neg = (funct3_i == F3_MULH || funct3_i == F3_MULHSU || funct3_i == F3_DIV || funct3_i == F3_REM) && a_i[XLEN-1];
    b_neg = (funct3_i == F3_MULH || funct3_i == F3_DIV || funct3_i == F3_REM) && b_i[XLEN-1];
    mag_a = a_neg ? -a_i : a_i;
    mag_b = b_neg ? -b_i : b_i;
    sum = hi_q + {1'b0, lo_q[0] ? m_q : {XLEN{1'b0}}};
  end
`ifdef ALU_CONTROL_MDU_DIV_EN
  logic div_q;
  logic [XLEN:0] sh, trial;
  // hi holds the partial remainder, lo shifts the dividend out and the quotient in
  always_comb begin
    is_div = funct3_i[2];
    div_q = f3_q[2];
    sh = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    trial = sh - {1'b0, m_q};
    hi_step = div_q ? (trial[XLEN] ? sh : trial) : {1'b0, sum[XLEN:1]};
    lo_step = div_q ? {lo_q[XLEN-2:0], !trial[XLEN]} : {sum[0], lo_q[XLEN-1:1]};
    fast_o = is_div && (b_i == '0 || (!funct3_i[0] && a_i == {1'b1, {(XLEN-1){1'b0}}} && b_i == '1));
    fast_res = b_i == '0 ? (funct3_i[1] ? a_i : '1) : (funct3_i[1] ? '0 : a_i);
  end
`else
  always_comb begin
    is_div = 1'b0;
    hi_step = {1'b0, sum[XLEN:1]};
    lo_step = {sum[0], lo_q[XLEN-1:1]};
    fast_o = 1'b0;
    fast_res = '0;
  end
`endif
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    m_d = m_q;
    f3_d = f3_q;
    an_d = an_q;
    bn_d = bn_q;
    cnt_d = cnt_q;
    if (start_i) begin
      hi_d = '0;
      lo_d = is_div ? mag_a : mag_b;
      m_d = is_div ? mag_b : mag_a;
      f3_d = funct3_i;
      an_d = a_neg;
      bn_d = b_neg;
      cnt_d = '0;
    end else if (step_i) begin
      hi_d = hi_step;
      lo_d = lo_step;
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_comb begin
    last_o = cnt_q == CW'(XLEN - 1);
    prod = {hi_d[XLEN-1:0], lo_d};
    prod_s = an_q ^ bn_q ? -prod : prod;
    fin = f3_q == F3_MUL ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`ifdef ALU_CONTROL_MDU_DIV_EN
    if (f3_q[2]) fin = f3_q[1] ? (an_q ? -hi_d[XLEN-1:0] : hi_d[XLEN-1:0]) : (an_q ^ bn_q ? -lo_d : lo_d);
`endif
    res_d = start_i && fast_o ? fast_res : step_i && last_o ? fin : res_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q <= '0;
      lo_q <= '0;
      m_q <= '0;
      f3_q <= '0;
      an_q <= 1'b0;
      bn_q <= 1'b0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q <= m_d;
      f3_q <= f3_d;
      an_q <= an_d;
      bn_q <= bn_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
    end
  end
  assign result_o = res_q;
endmodule

// File: rtl/alu_control_mdu.sv
// alu_control_mdu: RV32I ALU-op decoder plus iterative RV32M unit that stalls the core while busy.
// Define ALU_CONTROL_MDU_DIV_EN to build the divide/remainder operations.
module alu_control_mdu import alu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0]      alu_op_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      funct3_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  output logic [3:0]      alu_control_op_o,
  output logic            illegal_o,
  output logic            stall_o,
  output logic            mdu_valid_o,
  output logic [XLEN-1:0] mdu_result_o
);
`ifdef ALU_CONTROL_MDU_DIV_EN
  localparam logic DIV_EN = 1'b1;
`else
  localparam logic DIV_EN = 1'b0;
`endif
  alu_op_e op;
  mdu_state_e state_q, state_d;
  logic illegal, is_m, shift, start, fast, last, mdu_valid_q, mdu_valid_d;
  always_comb begin
    op = ALU_ADD;
    illegal = 1'b0;
    is_m = 1'b0;
    shift = funct3_i[1:0] == 2'b01;
    if (alu_op_i == SEL_SUB) op = ALU_SUB;
    else if (alu_op_i == SEL_OP && funct7_i == F7_MULDIV) begin
      is_m = DIV_EN || !funct3_i[2];
      illegal = !is_m;
    end else if (alu_op_i == SEL_OP) begin
      if (funct7_i == F7_BASE || (funct7_i == F7_ALT && (funct3_i == 3'b000 || funct3_i == 3'b101))) op = f3_op(funct3_i, funct7_i == F7_ALT);
      else illegal = 1'b1;
    end else if (alu_op_i == SEL_OP_IMM) begin
      if (!shift || funct7_i == F7_BASE || (funct3_i[2] && funct7_i == F7_ALT)) op = f3_op(funct3_i, shift && funct7_i == F7_ALT);
      else illegal = 1'b1;
    end
  end
  always_comb begin
    start = state_q == IDLE && valid_i && is_m;
    state_d = state_q == IDLE ? (start ? (fast ? DONE : BUSY) : IDLE) : state_q == BUSY ? (last ? DONE : BUSY) : IDLE;
    mdu_valid_d = state_d == DONE;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mdu_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mdu_valid_q <= mdu_valid_d;
    end
  end
  mdu_iter #(.XLEN(XLEN)) u_mdu_iter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start),
    .step_i   (state_q == BUSY),
    .funct3_i (funct3_i),
    .a_i      (operand_a_i),
    .b_i      (operand_b_i),
    .fast_o   (fast),
    .last_o   (last),
    .result_o (mdu_result_o)
  );
  assign alu_control_op_o = op;
  assign illegal_o = illegal;
  assign stall_o = !rst_i && (start || state_q == BUSY);
  assign mdu_valid_o = mdu_valid_q;
endmodule

// File: tb/tb_alu_control_mdu.sv
// tb_alu_control_mdu: decode table sweep plus scoreboarded M-extension runs against a 64-bit reference
module tb_alu_control_mdu;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic valid_i = 1'b0;
  logic [1:0] alu_op_i = 2'b00;
  logic [6:0] funct7_i = 7'h00;
  logic [2:0] funct3_i = 3'b000;
  logic [31:0] a = '0, b = '0;
  logic [3:0] op_o;
  logic ill_o, stall_o, mv_o;
  logic [31:0] res_o;
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  typedef struct packed {logic [1:0] sel; logic [6:0] f7; logic [2:0] f3; logic [3:0] op; logic ill;} dec_t;
  dec_t dec_tbl [21] = '{
    '{2'b10, 7'h20, 3'b101, 4'h7, 1'b0}, '{2'b10, 7'h20, 3'b001, 4'h2, 1'b1},
    '{2'b00, 7'h7f, 3'b111, 4'h2, 1'b0}, '{2'b01, 7'h7f, 3'b011, 4'h6, 1'b0},
    '{2'b10, 7'h00, 3'b000, 4'h2, 1'b0}, '{2'b10, 7'h20, 3'b000, 4'h6, 1'b0},
    '{2'b10, 7'h00, 3'b001, 4'h4, 1'b0}, '{2'b10, 7'h00, 3'b010, 4'h8, 1'b0},
    '{2'b10, 7'h00, 3'b011, 4'h9, 1'b0}, '{2'b10, 7'h00, 3'b100, 4'h3, 1'b0},
    '{2'b10, 7'h00, 3'b101, 4'h5, 1'b0}, '{2'b10, 7'h00, 3'b110, 4'h1, 1'b0},
    '{2'b10, 7'h00, 3'b111, 4'h0, 1'b0}, '{2'b10, 7'h7f, 3'b000, 4'h2, 1'b1},
    '{2'b11, 7'h20, 3'b000, 4'h2, 1'b0}, '{2'b11, 7'h20, 3'b101, 4'h7, 1'b0},
    '{2'b11, 7'h00, 3'b001, 4'h4, 1'b0}, '{2'b11, 7'h20, 3'b001, 4'h2, 1'b1},
    '{2'b11, 7'h01, 3'b101, 4'h2, 1'b1}, '{2'b11, 7'h55, 3'b010, 4'h8, 1'b0},
    '{2'b10, 7'h01, 3'b000, 4'h2, 1'b0}
  };
  always #5 clk = ~clk;
  alu_control_mdu #(.XLEN(32)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .alu_op_i         (alu_op_i),
    .funct7_i         (funct7_i),
    .funct3_i         (funct3_i),
    .valid_i          (valid_i),
    .operand_a_i      (a),
    .operand_b_i      (b),
    .alu_control_op_o (op_o),
    .illegal_o        (ill_o),
    .stall_o          (stall_o),
    .mdu_valid_o      (mv_o),
    .mdu_result_o     (res_o)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] sx, sy, ux, uy, p;
    logic ovf;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    ovf = x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
    case (f3)
      3'd0: p = {32'b0, 32'(ux * uy)};
      3'd1: p = {32'b0, 32'((sx * sy) >> 32)};
      3'd2: p = {32'b0, 32'((sx * uy) >> 32)};
      3'd3: p = {32'b0, 32'((ux * uy) >> 32)};
      3'd4: p = {32'b0, y == 0 ? 32'hFFFF_FFFF : ovf ? x : 32'($signed(x) / $signed(y))};
      3'd5: p = {32'b0, y == 0 ? 32'hFFFF_FFFF : x / y};
      3'd6: p = {32'b0, y == 0 ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y))};
      default: p = {32'b0, y == 0 ? x : x % y};
    endcase
    return p[31:0];
  endfunction
  // caller is in the low clock phase; the instruction is presented immediately
  task automatic run_m(input string tag, input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv, input int exp_stall);
    int n, cyc;
    logic [31:0] e;
    exp_q.push_back(ref_m(f3, av, bv));
    alu_op_i = 2'b10;
    funct7_i = F7_MULDIV;
    funct3_i = f3;
    a = av;
    b = bv;
    valid_i = 1'b1;
    n = 0;
    cyc = 0;
    #1;
    while (!mv_o && cyc < 100) begin
      if (stall_o) n++;
      @(negedge clk);
      valid_i = 1'b0;
      a = $urandom;
      b = $urandom;
      funct3_i = 3'($urandom_range(0, 7));
      cyc++;
      #1;
    end
    e = exp_q.pop_front();
    if (!mv_o) check({tag, "_timeout"}, mv_o, 1);
    else begin
      check(tag, res_o, e);
      check({tag, "_stall_cycles"}, n, exp_stall);
      check({tag, "_stall_in_done"}, stall_o, 0);
    end
    @(negedge clk);
    #1;
    check({tag, "_valid_one_cycle"}, mv_o, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", stall_o, 0);
    check("rst_valid", mv_o, 0);
    check("rst_result", res_o, 0);
    rst_i = 1'b0;
    foreach (dec_tbl[i]) begin
      @(negedge clk);
      alu_op_i = dec_tbl[i].sel;
      funct7_i = dec_tbl[i].f7;
      funct3_i = dec_tbl[i].f3;
      valid_i = !(dec_tbl[i].sel == 2'b10 && dec_tbl[i].f7 == F7_MULDIV);
      #1;
      check($sformatf("dec_op_%0d", i), op_o, dec_tbl[i].op);
      check($sformatf("dec_ill_%0d", i), ill_o, dec_tbl[i].ill);
      check($sformatf("dec_nostall_%0d", i), stall_o, 0);
    end
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    run_m("mulh", F3_MULH, 32'hFFFF_FFFF, 32'h2, 33);
    run_m("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'h2, 33);
    run_m("mul", F3_MUL, 32'h3, 32'h5, 33);
    run_m("mulhsu", F3_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 33);
    run_m("mul_neg", F3_MUL, 32'hFFFF_FFF9, 32'h0000_0013, 33);
    for (int i = 0; i < 4; i++) run_m($sformatf("mul_rand%0d", i), 3'($urandom_range(0, 3)), $urandom, $urandom, 33);
`ifdef ALU_CONTROL_MDU_DIV_EN
    run_m("div", F3_DIV, 32'hFFFF_FFF9, 32'h2, 33);
    run_m("rem", F3_REM, 32'hFFFF_FFF9, 32'h2, 33);
    run_m("divu_zero", F3_DIVU, 32'h0000_1234, 32'h0, 1);
    run_m("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_m("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_m("remu_zero", F3_REMU, 32'h0000_0055, 32'h0, 1);
    run_m("divu", F3_DIVU, 32'hFFFF_FFFF, 32'h10, 33);
    run_m("remu", F3_REMU, 32'hFFFF_FFFF, 32'h10, 33);
    for (int i = 0; i < 4; i++) run_m($sformatf("div_rand%0d", i), 3'(4 + $urandom_range(0, 3)), $urandom, $urandom | 32'h1, 33);
    funct3_i = F3_DIV;
`else
    alu_op_i = 2'b10;
    funct7_i = F7_MULDIV;
    funct3_i = F3_DIV;
    valid_i = 1'b1;
    #1;
    check("nodiv_illegal", ill_o, 1);
    check("nodiv_stall", stall_o, 0);
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    check("nodiv_not_started", mv_o, 0);
    check("nodiv_still_idle", stall_o, 0);
    @(negedge clk);
    funct3_i = F3_MULHU;
`endif
    alu_op_i = 2'b10;
    funct7_i = F7_MULDIV;
    a = 32'hFFFF_FFF9;
    b = 32'h2;
    valid_i = 1'b1;
    repeat (10) begin
      @(negedge clk);
      valid_i = 1'b0;
    end
    rst_i = 1'b1;
    #1;
    check("midrst_stall", stall_o, 0);
    check("midrst_valid", mv_o, 0);
    check("midrst_result", res_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    run_m("mul_after_rst", F3_MUL, 32'h3, 32'h5, 33);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_control_mdu.md
# alu_control_mdu

Parametrised successor to the single-cycle ALU control decoder: decodes the full RV32I OP/OP-IMM funct3/funct7 space into a 4-bit ALU operation and adds an iterative RV32M multiply/divide unit (MDU). Sits between the main control unit and the datapath ALU. For M-extension instructions it stalls the single-cycle core via `stall_o` until a result is ready. Every output is defined for every input; there are no X outputs.

## Interface
- `XLEN`, 32: operand and result width; must be even and at least 8.
- `clk_i` input 1: clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `alu_op_i` input 2: 00 = ADD (load/store), 01 = SUB (branch), 10 = OP, 11 = OP-IMM.
- `funct7_i` input 7: instruction bits [31:25].
- `funct3_i` input 3: instruction bits [14:12].
- `valid_i` input 1: the instruction on the inputs is live this cycle.
- `operand_a_i` input XLEN: rs1 value.
- `operand_b_i` input XLEN: rs2 value.
- `alu_control_op_o` output 4: ALU operation code, combinational.
- `illegal_o` output 1: undefined funct combination, combinational.
- `stall_o` output 1: hold PC and register-file writes.
- `mdu_valid_o` output 1: `mdu_result_o` valid for this cycle.
- `mdu_result_o` output XLEN: M-extension result; writeback selects it when `mdu_valid_o` is 1.

## Operation
- ALU codes:
  - AND 0000, OR 0001, ADD 0010, XOR 0011
  - SLL 0100, SRL 0101, SUB 0110, SRA 0111
  - SLT 1000, SLTU 1001
- Decode:
  - `alu_op_i` 00 gives ADD; 01 gives SUB.
  - 10 with funct7 0000000 or 0100000 maps by funct3. SUB and SRA require funct7 0100000.
  - 11 maps by funct3 with funct7 ignored, except for shifts: SRAI requires funct7 0100000, and SLLI/SRLI require 0000000.
  - Any other combination asserts `illegal_o` and outputs ADD.
- M operations: `alu_op_i` = 10 and funct7 = 0000001.
  - funct3 order: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - `alu_control_op_o` = ADD and is ignored by writeback.
- MDU states are IDLE, BUSY and DONE.
  - IDLE → BUSY when `valid_i` is 1 and the instruction is an M operation. Operands and funct3 are latched.
  - BUSY counts XLEN cycles, then moves to DONE.
  - DONE → IDLE unconditionally.
- Multiply: radix-2 shift-add over the magnitudes, producing a 2·XLEN-bit product.
  - Sign correction follows funct3: MULH treats both operands as signed; MULHSU treats a as signed and b as unsigned.
  - MUL returns the low XLEN bits. The MULH variants return the high XLEN bits.
- Divide: restoring, one quotient bit per cycle, on magnitudes.
  - The quotient sign is a XOR b (signed ops only).
  - The remainder takes the sign of the dividend.
- Fast path: the state machine goes IDLE → DONE directly, skipping BUSY.
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow, −2^(XLEN−1) ÷ −1: quotient = dividend; remainder = 0.
- Reset, including reset mid-operation:
  - The state returns to IDLE.
  - `stall_o`, `mdu_valid_o` and `mdu_result_o` go to 0 and the counter clears.

## Timing
- `stall_o` = (IDLE and `valid_i` and M operation) or BUSY. It is low in DONE.
- Normal latency: the acceptance cycle, then XLEN BUSY cycles, then 1 DONE cycle, for XLEN+2 cycles in total. Fast path: 2 cycles.
- `mdu_valid_o` is a registered output, high exactly in DONE. The core retires the instruction in that cycle.
- While BUSY, input changes are ignored; the latched operands are used.
- A back-to-back M instruction presented in the cycle after DONE is accepted normally from IDLE.
- `valid_i` = 0 while in IDLE means no start, and `stall_o` stays 0.
- Non-M instructions never stall and are decoded in the same cycle.

## Configuration
- `ALU_CONTROL_MDU_DIV_EN`
  - Defined: DIV, DIVU, REM and REMU execute as described.
  - Undefined: the divide logic is not compiled. funct3 1xx with funct7 0000001 asserts `illegal_o`, does not stall, and never starts the MDU. The MUL family is unaffected.

## Structure
- `alu_pkg` holds:
  - the `alu_op_e` enum (4-bit codes above)
  - the `alu_op_sel_e` enum for `alu_op_i`
  - the `mdu_state_e` enum
  - funct7 constants: 0000000, 0100000, 0000001
  - M funct3 constants
- Sub-module `mdu_iter` holds the shared shift/accumulate datapath, sign correction and counter. The top level holds the decoder and the state machine.

## Test plan
- Decode sweep: `alu_op_i` = 10, funct7 = 0100000, funct3 = 101 → `alu_control_op_o` = 0111 and `illegal_o` = 0. funct7 = 0100000, funct3 = 001 → `illegal_o` = 1 and ADD.
- MUL with XLEN = 32: a = 0xFFFF_FFFF, b = 0x0000_0002. MULH gives 0xFFFF_FFFF and MULHU gives 0x0000_0001, with `stall_o` high for exactly 33 cycles and `mdu_valid_o` high for 1.
- DIV: a = −7, b = 2 → quotient −3 (0xFFFF_FFFD). REM with the same operands → 0xFFFF_FFFF.
- Fast paths:
  - DIVU by 0 → 0xFFFF_FFFF.
  - REM of 0x8000_0000 by −1 → 0.
  - Each completes in 2 cycles.
- Reset: assert `rst_i` 10 cycles into a DIV. All outputs must be 0 immediately. After release, a new MUL 3 × 5 = 15 completes normally.
- Build without `ALU_CONTROL_MDU_DIV_EN`: issue DIV → `illegal_o` = 1 and `stall_o` = 0. MUL still returns correct results.
